// File: rtl/soc_gpio_pkg.sv
// Shared definitions for the single-pin GPIO controller: register map, PEND bit indices and bus FSM states.
// The optional glitch filter is enabled with the GPIO_CTRL_FILTER_EN macro.
package soc_gpio_pkg;

  localparam logic [4:0] GPIO_DIR_OFS  = 5'h00;
  localparam logic [4:0] GPIO_OUT_OFS  = 5'h04;
  localparam logic [4:0] GPIO_IN_OFS   = 5'h08;
  localparam logic [4:0] GPIO_IEN_OFS  = 5'h0C;
  localparam logic [4:0] GPIO_PEND_OFS = 5'h10;
  localparam logic [4:0] GPIO_FILT_OFS = 5'h14;

  localparam int unsigned GPIO_IRQ_RISE = 0;
  localparam int unsigned GPIO_IRQ_FALL = 1;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_t;

endpackage

// File: rtl/gpio_sync_filter.sv
// Two-flop pad synchronizer followed by an optional glitch filter producing the debounced level in_q.
// The filter counter and its threshold port exist only when GPIO_CTRL_FILTER_EN is defined.
module gpio_sync_filter
`ifdef GPIO_CTRL_FILTER_EN
  #(parameter int unsigned FILTER_W = 16)
`endif
  (
    input  logic                clk,
    input  logic                rst,
    input  logic                pad,
`ifdef GPIO_CTRL_FILTER_EN
    input  logic [FILTER_W-1:0] filt,
`endif
    output logic                in_q
  );

  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_CTRL_FILTER_EN
  logic [FILTER_W-1:0] cnt;

  // Counter is cleared when in_q is updated so a new disagreement always starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      in_q <= 1'b0;
    end else if (sync2 == in_q) begin
      cnt <= '0;
    end else if (cnt == filt) begin
      in_q <= sync2;
      cnt  <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + FILTER_W'(1);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= sync2;
    end
  end
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped single-pin GPIO: DIR/OUT/IN/IEN/PEND/FILT registers, valid/ready bus FSM, edge detect and irq.
// Define GPIO_CTRL_FILTER_EN to build the FILT register and glitch-filter counter.
module gpio_ctrl
  import soc_gpio_pkg::*;
#(
  parameter int unsigned FILTER_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        gpio_in,
  output logic        gpio_out,
  output logic        gpio_oe,
  output logic        irq
);

  bus_state_t  state;
  logic        reg_dir;
  logic        reg_out;
  logic [1:0]  reg_ien;
  logic [1:0]  reg_pend;
  logic        in_q;
  logic        in_d;
  logic [4:0]  ofs;
  logic        wr;
  logic [1:0]  edges;
  logic [1:0]  w1c;
  logic [31:0] rd_val;
  logic [31:0] filt_rd;
  logic        unused_ok;

  assign ofs      = {mem_addr[4:2], 2'b00};
  assign wr       = (state == BUS_IDLE) && mem_valid && (mem_wmask != 4'h0);
  assign gpio_oe  = reg_dir;
  assign gpio_out = reg_out;
  assign unused_ok = &{1'b0, mem_addr[1:0], mem_wmask, mem_wdata};

`ifdef GPIO_CTRL_FILTER_EN
  logic [FILTER_W-1:0] reg_filt;
  logic [31:0]         wbits;

  assign wbits   = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}}, {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
  assign filt_rd = 32'(reg_filt);

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_filt <= '0;
    end else if (wr && ofs == GPIO_FILT_OFS) begin
      reg_filt <= (reg_filt & ~wbits[FILTER_W-1:0]) | (mem_wdata[FILTER_W-1:0] & wbits[FILTER_W-1:0]);
    end
  end

  gpio_sync_filter #(.FILTER_W(FILTER_W)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .pad  (gpio_in),
    .filt (reg_filt),
    .in_q (in_q)
  );
`else
  logic [FILTER_W-1:0] unused_filt_w;

  assign unused_filt_w = '0;
  assign filt_rd       = '0;

  gpio_sync_filter u_sync (
    .clk  (clk),
    .rst  (rst),
    .pad  (gpio_in),
    .in_q (in_q)
  );
`endif

  always_comb begin
    edges = '0;
    edges[GPIO_IRQ_RISE] = in_q & ~in_d;
    edges[GPIO_IRQ_FALL] = ~in_q & in_d;
  end

  assign w1c = (wr && ofs == GPIO_PEND_OFS && mem_wmask[0]) ? mem_wdata[1:0] : 2'b00;

  always_comb begin
    rd_val = '0;
    case (ofs)
      GPIO_DIR_OFS:  rd_val[0]   = reg_dir;
      GPIO_OUT_OFS:  rd_val[0]   = reg_out;
      GPIO_IN_OFS:   rd_val[0]   = in_q;
      GPIO_IEN_OFS:  rd_val[1:0] = reg_ien;
      GPIO_PEND_OFS: rd_val[1:0] = reg_pend;
      GPIO_FILT_OFS: rd_val      = filt_rd;
      default:       rd_val      = '0;
    endcase
  end

  // A fresh edge ORs in after the W1C mask, so a same-cycle set wins over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BUS_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      reg_dir   <= 1'b0;
      reg_out   <= 1'b0;
      reg_ien   <= '0;
      reg_pend  <= '0;
      in_d      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      in_d     <= in_q;
      reg_pend <= (reg_pend & ~w1c) | edges;
      irq      <= |(reg_pend & reg_ien);
      case (state)
        BUS_IDLE: begin
          if (mem_valid) begin
            state     <= BUS_ACK;
            mem_ready <= 1'b1;
            mem_rdata <= rd_val;
            if (wr && mem_wmask[0]) begin
              case (ofs)
                GPIO_DIR_OFS: reg_dir <= mem_wdata[0];
                GPIO_OUT_OFS: reg_out <= mem_wdata[0];
                GPIO_IEN_OFS: reg_ien <= mem_wdata[1:0];
                default: ;
              endcase
            end
          end
        end
        BUS_ACK: begin
          state     <= BUS_IDLE;
          mem_ready <= 1'b0;
          mem_rdata <= '0;
        end
        default: begin
          state     <= BUS_IDLE;
          mem_ready <= 1'b0;
          mem_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: behavioural register/pipeline model plus directed literal checks and random traffic.
// Filter-specific expectations follow GPIO_CTRL_FILTER_EN.
module tb_gpio_ctrl;

  localparam int unsigned FW = 16;
  localparam logic [31:0] FMASK = (32'd1 << FW) - 32'd1;
  localparam int unsigned FSAT = 32'd1 << FW;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        gpio_in;
  logic        gpio_out;
  logic        gpio_oe;
  logic        irq;

  always #5 clk = ~clk;

  gpio_ctrl #(.FILTER_W(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .irq       (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: state after each rising edge.
  logic        m_dir, m_out, m_inq, m_ind, m_s1, m_s2, m_irq, m_ready;
  logic [1:0]  m_ien, m_pend;
  logic [31:0] m_rdata;
  int unsigned m_filt, m_run;
  logic        t_acc, t_inq;
  logic [1:0]  t_edge, t_w1c;
  logic [31:0] t_rd, t_merge;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0: return {31'd0, m_dir};
      3'd1: return {31'd0, m_out};
      3'd2: return {31'd0, m_inq};
      3'd3: return {30'd0, m_ien};
      3'd4: return {30'd0, m_pend};
      3'd5: return m_filt;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_dir = 0; m_out = 0; m_ien = 0; m_pend = 0; m_filt = 0; m_run = 0;
      m_s1 = 0; m_s2 = 0; m_inq = 0; m_ind = 0; m_irq = 0; m_ready = 0; m_rdata = 0;
    end else begin
      t_acc  = mem_valid && !m_ready;
      t_rd   = model_read(mem_addr);
      t_edge = {(!m_inq && m_ind), (m_inq && !m_ind)};
      m_irq  = |(m_pend & m_ien);
      t_inq  = m_inq;
`ifdef GPIO_CTRL_FILTER_EN
      // in_q follows sync2 once they have disagreed for FILT+1 consecutive cycles
      if (m_s2 != m_inq) begin
        if (m_run < FSAT) m_run++;
        if (m_run == m_filt + 1) begin
          t_inq = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
`else
      t_inq = m_s2;
`endif
      m_ind = m_inq;
      m_inq = t_inq;
      m_s2  = m_s1;
      m_s1  = gpio_in;
      t_w1c = 2'b00;
      if (t_acc && mem_wmask != 4'h0) begin
        case (mem_addr[4:2])
          3'd0: if (mem_wmask[0]) m_dir = mem_wdata[0];
          3'd1: if (mem_wmask[0]) m_out = mem_wdata[0];
          3'd3: if (mem_wmask[0]) m_ien = mem_wdata[1:0];
          3'd4: if (mem_wmask[0]) t_w1c = mem_wdata[1:0];
`ifdef GPIO_CTRL_FILTER_EN
          3'd5: begin
            t_merge = m_filt;
            for (int b = 0; b < 4; b++)
              if (mem_wmask[b]) t_merge[8*b +: 8] = mem_wdata[8*b +: 8];
            m_filt = t_merge & FMASK;
          end
`endif
          default: ;
        endcase
      end
      m_pend  = (m_pend & ~t_w1c) | t_edge;
      m_ready = t_acc;
      m_rdata = t_acc ? t_rd : 32'd0;
    end
  end

  always @(negedge clk) begin
    check("gpio_oe", gpio_oe, m_dir);
    check("gpio_out", gpio_out, m_out);
    check("irq", irq, m_irq);
    check("mem_ready", mem_ready, m_ready);
    if (m_ready) check("mem_rdata", mem_rdata, m_rdata);
  end

  task automatic bus(input logic [4:0] a, input logic [3:0] m, input logic [31:0] d,
                     output logic [31:0] r);
    bit got;
    int waits;
    @(negedge clk);
    mem_addr = a; mem_wmask = m; mem_wdata = d; mem_valid = 1'b1;
    got = 0; waits = 0; r = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        r = mem_rdata; got = 1; waits = i;
        break;
      end
    end
    mem_valid = 1'b0;
    if (!got) check("bus_timeout", 32'd0, 32'd1);
    else check("bus_latency", waits, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  logic [31:0] r, d;
  logic [4:0]  a;
  logic [3:0]  m;

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wmask = '0; mem_wdata = '0; gpio_in = 1'b0;
    idle(3);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      a = 5'(k * 4);
      bus(a, 4'h0, 32'd0, r);
      check("reset_read", r, 32'd0);
    end
    check("reset_oe", gpio_oe, 0);
    check("reset_out", gpio_out, 0);
    check("reset_irq", irq, 0);

    bus(5'h00, 4'h1, 32'd1, r);
    bus(5'h04, 4'h1, 32'd1, r);
    check("dir_oe", gpio_oe, 1);
    check("out_val", gpio_out, 1);
    bus(5'h04, 4'h0, 32'd0, r);
    check("out_read", r, 32'd1);
    bus(5'h06, 4'h2, 32'd0, r);
    check("out_upper_byte_write", gpio_out, 1);

    bus(5'h0C, 4'h1, 32'd1, r);
    gpio_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) check("irq_n4", irq, 0);
      if (k == 5) check("irq_n5", irq, 1);
    end
    bus(5'h08, 4'h0, 32'd0, r);
    check("in_read", r, 32'd1);
    bus(5'h10, 4'h0, 32'd0, r);
    check("pend_rise", r, 32'd1);
    bus(5'h10, 4'h1, 32'd1, r);
    idle(2);
    check("irq_cleared", irq, 0);
    bus(5'h10, 4'h0, 32'd0, r);
    check("pend_cleared", r, 32'd0);

    bus(5'h14, 4'h3, 32'd5, r);
    gpio_in = 1'b0;
    idle(14);
    bus(5'h10, 4'h1, 32'd3, r);
`ifdef GPIO_CTRL_FILTER_EN
    bus(5'h14, 4'h0, 32'd0, r);
    check("filt_read", r, 32'd5);
    gpio_in = 1'b1; idle(5); gpio_in = 1'b0; idle(14);
    bus(5'h08, 4'h0, 32'd0, r);
    check("glitch5_in", r, 32'd0);
    bus(5'h10, 4'h0, 32'd0, r);
    check("glitch5_pend", r, 32'd0);
    gpio_in = 1'b1; idle(6); gpio_in = 1'b0; idle(3);
    bus(5'h08, 4'h0, 32'd0, r);
    check("pulse6_in", r, 32'd1);
    idle(14);
    bus(5'h10, 4'h0, 32'd0, r);
    check("pulse6_pend", r, 32'd3);
`else
    bus(5'h14, 4'h0, 32'd0, r);
    check("filt_absent", r, 32'd0);
`endif
    bus(5'h14, 4'h3, 32'd0, r);

    gpio_in = 1'b1; idle(8);
    gpio_in = 1'b0; idle(8);
    gpio_in = 1'b1; idle(8);
    bus(5'h10, 4'h0, 32'd0, r);
    check("pend_both", r, 32'd3);
    gpio_in = 1'b0;
    idle(2);
    bus(5'h10, 4'h1, 32'd2, r);
    bus(5'h10, 4'h0, 32'd0, r);
    check("set_beats_w1c", r, 32'd3);

    bus(5'h0C, 4'h1, 32'd3, r);
    idle(2);
    check("irq_before_rst", irq, 1);
    @(negedge clk);
    mem_addr = 5'h10; mem_wmask = 4'h0; mem_valid = 1'b1;
    @(negedge clk);
    check("ack_before_rst", mem_ready, 1);
    rst = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    check("rst_ready", mem_ready, 0);
    check("rst_irq", irq, 0);
    check("rst_oe", gpio_oe, 0);
    check("rst_out", gpio_out, 0);
    check("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    bus(5'h10, 4'h0, 32'd0, r);
    check("rst_pend", r, 32'd0);

    for (int it = 0; it < 1500; it++) begin
      int act;
      act = $urandom_range(0, 99);
      if (act < 40) begin
        a = 5'($urandom_range(0, 31));
        m = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        d = (a[4:2] == 3'd5) ? 32'($urandom_range(0, 6)) : $urandom;
        bus(a, m, d, r);
      end else if (act < 98) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) gpio_in = ~gpio_in;
      end else begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
